prng_req_arbiter: RTL and testbench

//  Sequences a single Mersenne-Twister PRNG core and shares its output among NUM_REQ requesters.

---
 rtl/prng_req_arbiter.sv | 173 +++++++++++++++++
 tb/tb_prng_req_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/prng_req_arbiter.sv
// Sequences a Mersenne-Twister PRNG core (start/re_start pulses), buffers its words
// in a small FIFO and hands them out round-robin to NUM_REQ requesters.
module prng_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WATER  = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  output logic                          prng_start,
  output logic                          prng_restart,
  input  logic                          prng_valid,
  input  logic [DATA_WIDTH-1:0]         prng_data,
  input  logic [NUM_REQ-1:0]            req,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [DATA_WIDTH-1:0]         rnd_data,
  output logic                          rnd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          timeout_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int RW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_RESTART = 3'd2,
    ST_WAIT    = 3'd3,
    ST_ERR     = 3'd4
  } state_t;

  state_t                  state_r, state_s;
  logic                    seeded_r;
  logic [WW-1:0]           wd_r;
  logic                    prng_start_r, prng_restart_r, timeout_err_r;

  logic [DATA_WIDTH-1:0]   mem_r [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]           level_r;
  logic                    overflow_r;

  logic [RW-1:0]           rr_ptr_r, rr_nxt_s, gnt_idx_s;
  logic [NUM_REQ-1:0]      gnt_r;
  logic [DATA_WIDTH-1:0]   rnd_data_r;
  logic                    rnd_valid_r;

  logic                    pop_s, push_s, drop_s, full_s, empty_s;

  assign full_s  = (level_r == LW'(FIFO_DEPTH));
  assign empty_s = (level_r == {LW{1'b0}});
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the word.
  assign push_s  = prng_valid & (~full_s | pop_s);
  assign drop_s  = prng_valid & full_s & ~pop_s;

  // Round-robin search: first requester at or after rr_ptr_r, wrapping.
  always_comb begin : arb_comb
    int   idx;
    logic hit;
    gnt_idx_s = {RW{1'b0}};
    rr_nxt_s  = rr_ptr_r;
    pop_s     = 1'b0;
    idx       = 0;
    hit       = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx       = int'(rr_ptr_r) + i;
      idx       = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
      hit       = ~pop_s & req[RW'(idx)] & ~empty_s;
      gnt_idx_s = hit ? RW'(idx) : gnt_idx_s;
      rr_nxt_s  = hit ? ((idx == NUM_REQ - 1) ? {RW{1'b0}} : RW'(idx + 1)) : rr_nxt_s;
      pop_s     = pop_s | hit;
    end
  end

  // Sequencer next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable && !seeded_r) begin
          state_s = ST_START;
        end else if (enable && (level_r <= LW'(LOW_WATER))) begin
          state_s = ST_RESTART;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START:   state_s = ST_WAIT;
      ST_RESTART: state_s = ST_WAIT;
      ST_WAIT: begin
        if (prng_valid) begin
          state_s = ST_IDLE;
        end else if (wd_r == WW'(TIMEOUT - 1)) begin
          state_s = ST_ERR;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_ERR:     state_s = ST_ERR;
      default:    state_s = ST_IDLE;
    endcase
  end

  // Sequencer state, pulse outputs, watchdog and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_IDLE;
      seeded_r       <= 1'b0;
      wd_r           <= {WW{1'b0}};
      prng_start_r   <= 1'b0;
      prng_restart_r <= 1'b0;
      timeout_err_r  <= 1'b0;
    end else begin
      state_r        <= state_s;
      prng_start_r   <= (state_s == ST_START);
      prng_restart_r <= (state_s == ST_RESTART);
      if (state_r == ST_START) seeded_r <= 1'b1;
      wd_r           <= (state_r == ST_WAIT) ? (wd_r + WW'(1)) : {WW{1'b0}};
      if ((state_r == ST_WAIT) && (state_s == ST_ERR)) timeout_err_r <= 1'b1;
    end
  end

  // FIFO storage; contents need no reset since level_r gates every read.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= prng_data;
  end

  // FIFO pointers, exact occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      level_r    <= {LW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      level_r    <= level_r + LW'(push_s) - LW'(pop_s);
      overflow_r <= overflow_r | drop_s;
    end
  end

  // Registered grant, data hand-out and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r       <= {NUM_REQ{1'b0}};
      rnd_data_r  <= {DATA_WIDTH{1'b0}};
      rnd_valid_r <= 1'b0;
      rr_ptr_r    <= {RW{1'b0}};
    end else begin
      gnt_r       <= pop_s ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx_s) : {NUM_REQ{1'b0}};
      rnd_valid_r <= pop_s;
      if (pop_s) rnd_data_r <= mem_r[rd_ptr_r];
      rr_ptr_r    <= rr_nxt_s;
    end
  end

  assign prng_start   = prng_start_r;
  assign prng_restart = prng_restart_r;
  assign gnt          = gnt_r;
  assign rnd_data     = rnd_data_r;
  assign rnd_valid    = rnd_valid_r;
  assign fifo_level   = level_r;
  assign overflow     = overflow_r;
  assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_prng_req_arbiter.sv
// Randomized self-checking bench for prng_req_arbiter with a queue-based reference
// model of the FIFO/round-robin hand-out and a latency-programmable PRNG core stand-in.
module tb_prng_req_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int FD = 8;

  logic          clk = 1'b0;
  logic          rst_n, enable, prng_valid;
  logic [DW-1:0] prng_data;
  logic [NR-1:0] req;
  logic          prng_start, prng_restart, rnd_valid, overflow, timeout_err;
  logic [NR-1:0] gnt;
  logic [DW-1:0] rnd_data;
  logic [3:0]    fifo_level;

  prng_req_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .LOW_WATER(2), .TIMEOUT(4096)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .prng_start(prng_start), .prng_restart(prng_restart),
    .prng_valid(prng_valid), .prng_data(prng_data), .req(req), .gnt(gnt), .rnd_data(rnd_data),
    .rnd_valid(rnd_valid), .fifo_level(fifo_level), .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [DW-1:0] mq [$];
  int            m_rr;
  logic [NR-1:0] m_gnt;
  logic [DW-1:0] m_data;
  logic          m_ovf, m_to;

  // core stand-in
  bit core_on;
  int core_lat, pend, n_start, n_restart;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int g;
    m_gnt = '0;
    if (req != '0 && mq.size() > 0) begin
      g = -1;
      for (int i = 0; i < NR; i++)
        if (g < 0 && req[(m_rr + i) % NR]) g = (m_rr + i) % NR;
      m_gnt[g] = 1'b1;
      m_data   = mq.pop_front();
      m_rr     = (g + 1) % NR;
    end
    if (prng_valid) begin
      if (mq.size() < FD) mq.push_back(prng_data);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_val("gnt", gnt, m_gnt);
    check_val("rnd_valid", rnd_valid, |m_gnt);
    check_val("rnd_data", rnd_data, m_data);
    check_val("fifo_level", fifo_level, mq.size());
    check_val("overflow", overflow, m_ovf);
    check_val("timeout_err", timeout_err, m_to);
    check_val("pulse_excl", prng_start & prng_restart, 0);
    n_start   += int'(prng_start);
    n_restart += int'(prng_restart);
    prng_valid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        prng_valid = 1'b1;
        prng_data  = $urandom;
      end
    end
    if (core_on && (prng_start || prng_restart)) pend = core_lat;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; req = '0; prng_valid = 1'b0; prng_data = '0;
    pend = 0; mq.delete(); m_rr = 0; m_gnt = '0; m_data = '0; m_ovf = 1'b0; m_to = 1'b0;
    n_start = 0; n_restart = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_outs", {gnt, rnd_valid, fifo_level, overflow, timeout_err, prng_start, prng_restart}, 0);
    check_val("rst_data", rnd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic inject(input logic [DW-1:0] d);
    prng_valid = 1'b1;
    prng_data  = d;
  endtask

  initial begin
    logic [DW-1:0] snap [$];
    int            gcount;
    bit            seen;

    // 1: start then refills up to level 3
    core_on = 1'b1; core_lat = 640;
    do_reset();
    enable = 1'b1;
    for (int n = 0; n < 2700; n++) begin
      tick();
      if (prng_restart) check_val("t1_restart_level", fifo_level <= 4'd2, 1);
    end
    check_val("t1_starts", n_start, 1);
    check_val("t1_restarts", n_restart, 2);
    check_val("t1_level", fifo_level, 3);

    // 2: three words served round-robin, then nothing until the next push
    snap = mq;
    req = 4'b1111;
    tick(); check_val("t2_gnt0", gnt, 4'b0001); check_val("t2_data0", rnd_data, snap[0]);
    tick(); check_val("t2_gnt1", gnt, 4'b0010); check_val("t2_data1", rnd_data, snap[1]);
    tick(); check_val("t2_gnt2", gnt, 4'b0100); check_val("t2_data2", rnd_data, snap[2]);
    gcount = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      gcount += int'(rnd_valid);
    end
    check_val("t2_no_more_gnt", gcount, 0);
    req = '0;
    enable = 1'b0;
    repeat (700) tick();

    // 3: wrap from rr_ptr=2
    do_reset();
    for (int n = 0; n < 3; n++) begin inject($urandom); tick(); end
    req = 4'b0010; tick(); check_val("t3_setup", gnt, 4'b0010);
    req = 4'b0011; tick(); check_val("t3_wrap", gnt, 4'b0001);
    tick(); check_val("t3_next", gnt, 4'b0010);
    req = '0; tick();

    // 4: full FIFO, push+pop then push without pop
    do_reset();
    for (int n = 0; n < FD; n++) begin inject($urandom); tick(); end
    check_val("t4_full", fifo_level, FD);
    inject(32'hA5A5_0001); req = 4'b0001; tick();
    check_val("t4_pushpop_level", fifo_level, FD);
    check_val("t4_pushpop_ovf", overflow, 0);
    req = '0; inject(32'hDEAD_BEEF); tick();
    check_val("t4_drop_ovf", overflow, 1);
    check_val("t4_drop_level", fifo_level, FD);
    req = 4'b1111;
    repeat (10) tick();
    req = '0;

    // 5: silent core -> timeout, reset recovers
    do_reset();
    core_on = 1'b0;
    enable = 1'b1;
    for (int n = 1; n <= 4200; n++) begin
      if (n == 4098) m_to = 1'b1;
      tick();
    end
    check_val("t5_timeout", timeout_err, 1);
    check_val("t5_starts", n_start, 1);
    check_val("t5_restarts", n_restart, 0);
    do_reset();
    core_on = 1'b1; core_lat = 3;
    enable = 1'b1;
    repeat (10) tick();
    check_val("t5_restart_after_rst", n_start, 1);

    // 6: enable falls just after a restart pulse
    do_reset();
    core_lat = 5;
    enable = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      tick();
      seen = prng_restart;
    end
    check_val("t6_restart_seen", seen, 1);
    tick();
    enable = 1'b0;
    n_start = 0; n_restart = 0;
    repeat (100) tick();
    check_val("t6_no_pulses", n_start + n_restart, 0);
    check_val("t6_level", fifo_level, 2);

    // 7: randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      core_lat = $urandom_range(1, 20);
      req      = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      enable   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) inject($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
